// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, funct3 width codes
// and the load/store unit state encoding.
package rv32i_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_e;

    // True when funct3 names a width/sign form that exists
    // for the given direction.
    function automatic logic f3_legal(
        input logic       is_load,
        input logic [2:0] f3
    );
        if (is_load)
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/rv32i_load_store_unit_if.sv
// Data memory req/ack bus between the load/store unit
// (master) and the data memory (slave).
interface rv32i_load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for loads and stores: byte enables,
// store replication, load extension and alignment check.
module lsu_align (
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o,
    output logic        misaligned_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        sx;

    // Pick the addressed byte and halfword out of the read word
    always_comb begin
        byte_v = rdata_i[7:0];
        unique case (off_i)
            2'd0: byte_v = rdata_i[7:0];
            2'd1: byte_v = rdata_i[15:8];
            2'd2: byte_v = rdata_i[23:16];
            2'd3: byte_v = rdata_i[31:24];
        endcase
        half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Width decides enables, replication, extension, alignment
    always_comb begin
        sx           = ~funct3_i[2];
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        ldata_o      = rdata_i;
        misaligned_o = 1'b0;
        unique case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = {{24{sx & byte_v[7]}}, byte_v};
            end
            2'b01: begin
                be_o         = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{wdata_i[15:0]}};
                ldata_o      = {{16{sx & half_v[15]}}, half_v};
                misaligned_o = off_i[0];
            end
            default: begin
                be_o         = 4'b1111;
                wdata_o      = wdata_i;
                ldata_o      = rdata_i;
                misaligned_o = (off_i != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/rv32i_load_store_unit.sv
// RV32I memory stage: one load/store per request over a
// req/ack data bus, with alignment faults and bus timeout.
module rv32i_load_store_unit
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              regwr,
    output logic [31:0]       regwrdata,
    output logic [4:0]        rd_out,
    rv32i_load_store_unit_if.master dmem
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        f3_q;
    logic [31:0]       wdata_q;
    logic [4:0]        rd_q;
    logic              memread_q, memwrite_q;
    logic [31:0]       regwrdata_q;

    logic        idle, acc, take, load_ok, legal_in;
    logic [2:0]  a_f3;
    logic [1:0]  a_off;
    logic [31:0] a_wdata;
    logic [3:0]  a_be;
    logic [31:0] a_wrep, a_ldata;
    logic        a_mis;

    assign idle = (state_q == LSU_IDLE);
    assign acc  = (state_q == LSU_ACCESS);
    assign take = idle & start;
    assign load_ok = acc & dmem.dmem_ack & memread_q;
    assign legal_in = (memread ^ memwrite) & f3_legal(memread, funct3);

    // The aligner checks the incoming request while idle and
    // steers the latched request for the rest of the access.
    assign a_f3    = idle ? funct3 : f3_q;
    assign a_off   = idle ? addr[1:0] : addr_q[1:0];
    assign a_wdata = idle ? wdata : wdata_q;

    lsu_align u_align (
        .funct3_i     (a_f3),
        .off_i        (a_off),
        .wdata_i      (a_wdata),
        .rdata_i      (dmem.dmem_rdata),
        .be_o         (a_be),
        .wdata_o      (a_wrep),
        .ldata_o      (a_ldata),
        .misaligned_o (a_mis)
    );

    // Next-state, timeout count and fault outcome
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (start) begin
                    cnt_d = '0;
                    if (!legal_in || a_mis) begin
                        state_d = LSU_DONE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = LSU_ACCESS;
                        fault_d = 1'b0;
                    end
                end
            end
            LSU_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem.dmem_ack) begin
                    state_d = LSU_DONE;
                    fault_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d = LSU_DONE;
                    fault_d = 1'b1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Request latches and formatted load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            f3_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            memread_q   <= 1'b0;
            memwrite_q  <= 1'b0;
            regwrdata_q <= '0;
        end else begin
            if (take) begin
                addr_q     <= addr;
                f3_q       <= funct3;
                wdata_q    <= wdata;
                rd_q       <= rd;
                memread_q  <= memread;
                memwrite_q <= memwrite;
            end
            if (load_ok)
                regwrdata_q <= a_ldata;
        end
    end

    assign busy      = ~idle;
    assign done      = (state_q == LSU_DONE);
    assign fault     = done & fault_q;
    assign regwr     = done & memread_q & ~fault_q;
    assign regwrdata = regwrdata_q;
    assign rd_out    = rd_q;

    assign dmem.dmem_req   = acc;
    assign dmem.dmem_we    = acc & memwrite_q;
    assign dmem.dmem_addr  = acc ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem.dmem_be    = acc ? a_be : 4'b0000;
    assign dmem.dmem_wdata = acc ? a_wrep : 32'h0;
endmodule

// File: tb/tb_rv32i_load_store_unit.sv
// Randomized check of the load/store unit against a
// byte-arithmetic reference model.
module tb_rv32i_load_store_unit;
    import rv32i_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, memread, memwrite;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        busy, done, fault, regwr;
    logic [31:0] regwrdata;
    logic [4:0]  rd_out;

    int nchk = 0;
    int nerr = 0;
    logic [31:0] m_rwd;

    rv32i_load_store_unit_if #(.ADDR_W(32)) dbus ();

    rv32i_load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .memread   (memread),
        .memwrite  (memwrite),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rd        (rd),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .regwr     (regwr),
        .regwrdata (regwrdata),
        .rd_out    (rd_out),
        .dmem      (dbus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_legal(bit mr, bit mw, logic [2:0] f3);
        if (mr == mw) return 1'b0;
        if (mr) return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return f3 inside {3'd0, 3'd1, 3'd2};
    endfunction

    function automatic int m_size(logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [3:0] m_be(int size, int off);
        int t;
        t = ((1 << size) - 1) << off;
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wrep(int size, logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = w[8*(i % size) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, int off,
                                           logic [31:0] rdata);
        int          size;
        logic [31:0] v, mask;
        size = m_size(f3);
        v = rdata >> (8 * off);
        if (size < 4) begin
            mask = (32'h1 << (8 * size)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*size-1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic run_op(input bit mr, input bit mw,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r,
                          input int waits, input logic [31:0] rdat,
                          input bit inject);
        int  size, off, exp_lat, exp_req, lat, reqs;
        bit  early, tmo, exp_fault, exp_regwr;
        size = m_size(f3);
        off = int'(a[1:0]);
        early = !m_legal(mr, mw, f3) || ((off % size) != 0);
        tmo = !early && (waits >= TO);
        exp_lat = early ? 1 : (tmo ? TO + 1 : waits + 2);
        exp_req = early ? 0 : (tmo ? TO : waits + 1);
        exp_fault = early || tmo;
        exp_regwr = !exp_fault && mr;
        if (exp_regwr) m_rwd = m_load(f3, off, rdat);

        @(negedge clk);
        start = 1'b1; memread = mr; memwrite = mw;
        funct3 = f3; addr = a; wdata = wd; rd = r;
        lat = 0; reqs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            dbus.dmem_ack = 1'b0;
            if (dbus.dmem_req) begin
                reqs++;
                check("dmem_addr", dbus.dmem_addr, {a[31:2], 2'b00});
                check("dmem_we", 32'(dbus.dmem_we), 32'(mw));
                check("dmem_be", 32'(dbus.dmem_be), 32'(m_be(size, off)));
                if (mw)
                    check("dmem_wdata", dbus.dmem_wdata, m_wrep(size, wd));
                dbus.dmem_rdata = rdat;
                if (reqs == waits + 1) dbus.dmem_ack = 1'b1;
                if (inject && reqs == 1) begin
                    start = 1'b1; memread = 1'b1; memwrite = 1'b0;
                    funct3 = F3_W; addr = 32'h0; rd = 5'd31;
                end
            end
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("req_cycles", 32'(reqs), 32'(exp_req));
        check("fault", 32'(fault), 32'(exp_fault));
        check("regwr", 32'(regwr), 32'(exp_regwr));
        check("regwrdata", regwrdata, m_rwd);
        check("rd_out", 32'(rd_out), 32'(r));
        @(negedge clk);
        start = 1'b0;
        dbus.dmem_ack = 1'b0;
        check("done_pulse", 32'(done), 32'h0);
        check("idle_after", 32'(busy), 32'h0);
    endtask

    initial begin
        int sel;
        bit mr, mw;
        rst = 1'b1; start = 1'b0; memread = 1'b0; memwrite = 1'b0;
        funct3 = '0; addr = '0; wdata = '0; rd = '0;
        dbus.dmem_ack = 1'b0; dbus.dmem_rdata = '0;
        m_rwd = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_regwr", 32'(regwr), 32'h0);
        check("rst_regwrdata", regwrdata, 32'h0);
        check("rst_rd_out", 32'(rd_out), 32'h0);
        check("rst_req", 32'(dbus.dmem_req), 32'h0);
        check("rst_we", 32'(dbus.dmem_we), 32'h0);
        check("rst_addr", dbus.dmem_addr, 32'h0);
        check("rst_be", 32'(dbus.dmem_be), 32'h0);
        check("rst_wdata", dbus.dmem_wdata, 32'h0);
        rst = 1'b0;

        run_op(1, 0, F3_W, 32'h20, 32'h0, 5'd5, 0, 32'hDEADBEEF, 0);
        check("lw_value", regwrdata, 32'hDEADBEEF);
        run_op(1, 0, F3_B, 32'h23, 32'h0, 5'd6, 0, 32'h80112233, 0);
        check("lb_sext", regwrdata, 32'hFFFFFF80);
        run_op(1, 0, F3_BU, 32'h23, 32'h0, 5'd7, 0, 32'h80112233, 0);
        check("lbu_zext", regwrdata, 32'h00000080);
        run_op(0, 1, F3_H, 32'h12, 32'h0000ABCD, 5'd8, 3, 32'h0, 0);
        run_op(1, 0, F3_W, 32'h22, 32'h0, 5'd9, 0, 32'h12345678, 0);
        check("mis_keeps", regwrdata, 32'h00000080);
        run_op(1, 1, F3_W, 32'h40, 32'h0, 5'd10, 0, 32'h12345678, 0);
        run_op(1, 0, F3_W, 32'h44, 32'h0, 5'd11, TO, 32'h0, 1);
        run_op(1, 0, F3_H, 32'h46, 32'h0, 5'd12, TO - 1, 32'h8001CAFE, 0);

        @(negedge clk);
        start = 1'b1; memread = 1'b1; memwrite = 1'b0;
        funct3 = F3_W; addr = 32'h40; rd = 5'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre_rst_req", 32'(dbus.dmem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("arst_req", 32'(dbus.dmem_req), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_regwr", 32'(regwr), 32'h0);
        check("arst_regwrdata", regwrdata, 32'h0);
        m_rwd = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(1, 0, F3_W, 32'h80, 32'h0, 5'd4, 1, 32'hA5A55A5A, 0);

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            mr = (sel < 5) || (sel == 9 && $urandom_range(0, 1) == 1);
            mw = (sel >= 5 && sel < 9) || (sel == 9 && mr);
            run_op(mr, mw, 3'($urandom_range(0, 7)), $urandom,
                   $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 5), $urandom,
                   $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 nchk, nerr);
        $finish;
    end
endmodule

// File: doc/rv32i_load_store_unit.md
Name: rv32i_load_store_unit

Overview:
- Memory stage that sits directly downstream of the decoder/ALU.
- Accepts a load or store request: effective address from the ALU result, store data from rs2, funct3, destination rd.
- Runs a req/ack transaction with data memory, which may insert wait states.
- Returns sign/zero-extended load data with a register write-enable for writeback. Handles byte-lane alignment, misalignment faults and a bus timeout.

Parameters:
- TIMEOUT, 16: maximum ACCESS cycles without dmem_ack before the access is aborted with a fault (legal range 1..255).
- ADDR_W, 32: width of addr and dmem_addr.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request valid; sampled only in IDLE
- memread  in  1  request is a load
- memwrite  in  1  request is a store
- funct3  in  3  RV32I width/sign code
- addr  in  ADDR_W  effective byte address (ALU result)
- wdata  in  32  store data (rs2)
- rd  in  5  load destination register
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done: misaligned, illegal or timed-out access
- regwr  out  1  one-cycle write-enable to the register file; successful loads only
- regwrdata  out  32  formatted load data; holds its value until the next successful load
- rd_out  out  5  latched rd, qualifies regwr
- dmem_req  out  1  memory request; held high until ack or timeout
- dmem_we  out  1  store strobe, qualifies dmem_req
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read data; valid in the cycle dmem_ack is high
- dmem_ack  in  1  memory completion

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including regwrdata, rd_out and the timeout counter.
- State machine: IDLE, ACCESS, DONE.
- IDLE, start=1 at a rising edge:
  - Latch addr, funct3, wdata, rd, memread and memwrite.
  - Legal and aligned request -> ACCESS.
  - Otherwise -> DONE with fault=1; dmem_req never asserts.
- Illegal request, any of:
  - memread and memwrite both 1, or both 0.
  - Load funct3 not in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Store funct3 not in {000 SB, 001 SH, 010 SW}.
- Misaligned request:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]!=00.
- ACCESS:
  - dmem_req=1; dmem_we=memwrite; dmem_addr, dmem_be and dmem_wdata stay stable for the whole state.
  - dmem_ack=1 at an edge -> DONE with fault=0; a load also latches its formatted data.
  - The counter increments every ACCESS cycle. After TIMEOUT cycles with no ack -> DONE with fault=1. A late ack is ignored.
- DONE:
  - done=1 for exactly one cycle; then unconditionally -> IDLE.
  - Successful load: regwr=1 and regwrdata updated in this same cycle.
  - Stores and faults: regwr=0.
- start while busy is ignored; no queueing.
- Latency: zero-wait memory gives done two edges after the start edge; each memory wait state adds one cycle. Fault without access: done one edge after start.
- Store lanes (off=addr[1:0]):
  - SB: be=0001<<off; wdata[7:0] replicated into all four bytes.
  - SH: be=0011<<(2*addr[1]); wdata[15:0] replicated into both halves.
  - SW: be=1111.
- Load formatting:
  - LB/LBU: byte rdata[8*off+7:8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: halfword selected by addr[1], extended the same way.
  - LW: rdata unchanged.
- Reset asserted during ACCESS: dmem_req drops immediately (asynchronously); no done or regwr is produced.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - LSU state enumeration.
  - Opcode constants LOAD=0000011 and STORE=0100011, shared with the decoder.
- One combinational sub-module, lsu_align:
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, lane-replicated wdata, formatted load data, misaligned flag.
- The FSM, latches and timeout counter remain in the top module.

Test Plan:
- LW addr=0x00000020, memory acks in the first ACCESS cycle with rdata=0xDEADBEEF:
  - dmem_addr=0x20, be=1111, dmem_we=0.
  - done two edges after start; regwr=1, regwrdata=0xDEADBEEF, rd_out=rd.
- LB addr=0x23, rdata=0x80112233:
  - regwrdata=0xFFFFFF80.
  - Repeat as LBU: regwrdata=0x00000080.
- SH addr=0x12, wdata=0x0000ABCD, ack after 3 wait states:
  - dmem_addr=0x10, be=1100, dmem_wdata=0xABCDABCD, held stable for 4 ACCESS cycles.
  - done with regwr=0, fault=0.
- LW addr=0x22, then memread=memwrite=1:
  - Each produces done and fault one edge after start.
  - dmem_req never rises; regwr=0; regwrdata keeps its previous value.
- TIMEOUT=4, dmem_ack tied low:
  - dmem_req high for exactly 4 cycles, then done=1, fault=1.
  - A second start issued while busy is ignored.
- Assert rst mid-ACCESS:
  - dmem_req, busy and done go to 0 immediately; state returns to IDLE.
  - A fresh LW after rst deasserts completes normally.
